// File: rtl/if_stage_if.sv
// Signal bundle between the fetch stage and its neighbours (hazard unit, ID, instruction memory).
// slave = the fetch stage itself; master = everything driving it.
interface if_stage_if;
   logic [1:0]  stall;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] IFID_pc;
   logic [31:0] IFID_instr;
   logic        IFID_valid;
   logic        IFID_PredictBranchTaken;
   logic        bubble;
   logic [1:0]  dbg_cnt;

   // Handshake: no valid/ready. stall/flush are sampled every rising edge; redirect_pc is
   // meaningful only while flush=1; upd_* are meaningful only while upd_valid=1.
   modport slave (
      input  stall, flush, redirect_pc, imem_rdata, upd_valid, upd_pc, upd_taken,
      output imem_addr, IFID_pc, IFID_instr, IFID_valid, IFID_PredictBranchTaken, bubble, dbg_cnt
   );

   modport master (
      output stall, flush, redirect_pc, imem_rdata, upd_valid, upd_pc, upd_taken,
      input  imem_addr, IFID_pc, IFID_instr, IFID_valid, IFID_PredictBranchTaken, bubble, dbg_cnt
   );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction-fetch stage: PC register, IF/ID register and stall hold counter.
// Optional BHT branch predictor enabled by defining BHT_PREDICT_EN.
module if_stage #(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter int          BHT_IDX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   if_stage_if.slave   bus
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0] r_pc;
   logic [31:0] r_ifid_pc;
   logic [31:0] r_ifid_instr;
   logic        r_ifid_valid;
   logic        r_ifid_pred;
   logic [1:0]  r_cnt;

   logic [1:0]  w_cnt_next;
   logic [1:0]  w_cnt_dec;
   logic [1:0]  w_stall_m1;
   logic        w_hold;
   logic        w_bubble;
   logic        w_pred;
   logic [31:0] w_bimm;
   logic [31:0] w_next_pc;
   logic [BHT_IDX_BITS-1:0] w_look_idx;

   assign w_look_idx = r_pc[BHT_IDX_BITS+1:2];
   assign w_bimm = {{19{bus.imem_rdata[31]}}, bus.imem_rdata[31], bus.imem_rdata[7],
                    bus.imem_rdata[30:25], bus.imem_rdata[11:8], 1'b0};

`ifdef BHT_PREDICT_EN
   localparam int BHT_N = 1 << BHT_IDX_BITS;

   logic [1:0]              r_bht [BHT_N];
   logic [BHT_IDX_BITS-1:0] w_upd_idx;

   assign w_upd_idx = bus.upd_pc[BHT_IDX_BITS+1:2];
   // Lookup reads the registered table, so a same-cycle update is not visible yet.
   assign w_pred = (bus.imem_rdata[6:0] == 7'b1100011) && r_bht[w_look_idx][1];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
      end else if (bus.upd_valid) begin
         if (bus.upd_taken && (r_bht[w_upd_idx] != 2'b11))
            r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'b01;
         else if (!bus.upd_taken && (r_bht[w_upd_idx] != 2'b00))
            r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'b01;
      end
   end
`else
   logic w_unused_upd;

   assign w_pred       = 1'b0;
   assign w_unused_upd = ^{bus.upd_valid, bus.upd_pc, bus.upd_taken, w_look_idx};
`endif

   assign w_next_pc = w_pred ? (r_pc + w_bimm) : (r_pc + 32'd4);

   // Hold counter: state register.
   always_ff @(posedge clk) begin
      if (rst) r_cnt <= 2'd0;
      else     r_cnt <= w_cnt_next;
   end

   // Hold counter: next state. A new request may extend a running hold, never shorten it.
   always_comb begin
      w_cnt_dec  = (r_cnt == 2'd0) ? 2'd0 : (r_cnt - 2'd1);
      w_stall_m1 = bus.stall - 2'd1;
      w_cnt_next = w_cnt_dec;
      if (bus.flush)
         w_cnt_next = 2'd0;
      else if (bus.stall != 2'd0)
         w_cnt_next = (w_stall_m1 > w_cnt_dec) ? w_stall_m1 : w_cnt_dec;
   end

   // Hold counter: outputs.
   always_comb begin
      w_hold   = (bus.stall != 2'd0) || (r_cnt != 2'd0);
      w_bubble = w_hold && !bus.flush;
   end

   // PC and IF/ID register; priority rst > flush > hold > advance.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc         <= RESET_PC;
         r_ifid_pc    <= 32'd0;
         r_ifid_instr <= NOP;
         r_ifid_valid <= 1'b0;
         r_ifid_pred  <= 1'b0;
      end else if (bus.flush) begin
         r_pc         <= bus.redirect_pc;
         r_ifid_instr <= NOP;
         r_ifid_valid <= 1'b0;
         r_ifid_pred  <= 1'b0;
      end else if (!w_hold) begin
         r_pc         <= w_next_pc;
         r_ifid_pc    <= r_pc;
         r_ifid_instr <= bus.imem_rdata;
         r_ifid_valid <= 1'b1;
         r_ifid_pred  <= w_pred;
      end
   end

   assign bus.imem_addr               = r_pc;
   assign bus.IFID_pc                 = r_ifid_pc;
   assign bus.IFID_instr              = r_ifid_instr;
   assign bus.IFID_valid              = r_ifid_valid;
   assign bus.IFID_PredictBranchTaken = r_ifid_pred;
   assign bus.bubble                  = w_bubble;
   assign bus.dbg_cnt                 = r_cnt;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RV32I pipeline: owns the PC register and the IF/ID pipeline register.
- Consumes the hazard unit's stall[1:0] and flush, plus the redirect PC from ID.
- Converts a 1- or 2-cycle stall request into a held PC/IF-ID plus a bubble request toward ID/EX.
- Produces the branch-prediction bit that ID later compares against the resolved outcome.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BHT_IDX_BITS, 6, log2 of BHT entries; used only when BHT_PREDICT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  2  hold request from hazard unit: 0 none, 1 one cycle, 2 two cycles.
- flush  in  1  mispredict; redirect and squash IF/ID.
- redirect_pc  in  32  correct next PC from ID, valid when flush=1.
- imem_addr  out  32  instruction memory address; equals PC, combinational.
- imem_rdata  in  32  instruction word, combinational read of imem_addr.
- upd_valid  in  1  branch resolved in ID this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  resolved direction.
- IFID_pc  out  32  PC of the instruction in IF/ID.
- IFID_instr  out  32  instruction in IF/ID.
- IFID_valid  out  1  IF/ID holds a real instruction.
- IFID_PredictBranchTaken  out  1  prediction made at fetch.
- bubble  out  1  zero ID/EX control signals this cycle.

Behaviour:
- Reset (rst=1 at a clock edge): PC=RESET_PC, IFID_pc=0, IFID_instr=32'h0000_0013 (NOP), IFID_valid=0, IFID_PredictBranchTaken=0, hold counter cnt=0.
- Reset mid-stall or mid-flush discards all pending state.
- hold = (stall!=0) || (cnt!=0), combinational. bubble = hold && !flush.
- Counter update, when flush=0:
  - stall!=0: cnt <= max(cnt-1, stall-1), floored at 0.
  - otherwise: cnt <= cnt-1, saturating at 0.
  - stall=2 from idle: hold for 2 consecutive cycles.
  - stall=1 from idle: hold for 1 cycle.
  - A new request during a hold extends the hold; it never shortens it.
- Priority per edge: rst > flush > hold > advance.
- flush=1 (overrides any stall or cnt): PC <= redirect_pc, IFID_instr <= NOP, IFID_valid <= 0, IFID_PredictBranchTaken <= 0, cnt <= 0.
- hold=1, flush=0: PC and all IF/ID outputs keep their values. imem_addr stays stable.
- Advance:
  - IFID_pc <= PC, IFID_instr <= imem_rdata, IFID_valid <= 1, IFID_PredictBranchTaken <= pred.
  - PC <= pred ? PC + Bimm(imem_rdata) : PC + 4.
  - Arithmetic is 32-bit with wrap-around at 2^32.
- Base build: pred = 0.
- Latency: a fetch issued at PC in cycle N appears on IFID_* after edge N+1.
- Unaligned redirect_pc (low bits != 0) is passed through unchanged; alignment checking is ID's job.

Optional Feature:
- Macro: BHT_PREDICT_EN.
- Defined:
  - Table of 2^BHT_IDX_BITS 2-bit saturating counters, indexed by pc[BHT_IDX_BITS+1:2]; all entries reset to 2'b01 (weakly not-taken).
  - pred = (imem_rdata[6:0]==7'b1100011) && counter[PC idx][1].
  - Target = PC + sign-extended B-immediate {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - upd_valid=1: counter[upd_pc idx] increments on taken, decrements otherwise, saturating at 0 and 3. Updates apply even while hold or flush is asserted.
  - Lookup and update to the same index in the same cycle: lookup returns the pre-update value.
- Not defined: no table; pred = 0; upd_* are ignored; next PC is always PC+4 except on flush.

Test Plan:
- Reset then free-run with imem returning addr-tagged words -> IFID_pc = 0, 4, 8, 12 on successive cycles; IFID_valid rises one cycle after reset deasserts.
- With PC=0x10, pulse stall=1 for one cycle -> PC holds 0x10 for 1 cycle, bubble=1 for 1 cycle, then resumes 0x14.
- With PC=0x20, pulse stall=2 for one cycle only -> PC and IF/ID held 2 cycles, bubble high 2 cycles.
- stall=2 then flush=1 on the next cycle with redirect_pc=0x100 -> PC=0x100, IFID_instr=0x00000013, IFID_valid=0, cnt=0, no further hold.
- stall=1 and flush=1 in the same cycle, redirect_pc=0x40 -> flush wins, bubble=0, PC=0x40.
- BHT_PREDICT_EN: send BEQ at 0x8 with imm=+16 twice, with upd_taken=1 after each resolve -> first fetch predicts not-taken; after two taken updates the counter reads 3, the next fetch predicts taken with PC=0x18 and IFID_PredictBranchTaken=1.
